jtframe_pocket_dwnld: RTL and testbench



---
 rtl/jtframe_pocket_pkg.sv | 21 ++
 rtl/jtframe_pocket_dwnld_if.sv | 28 ++
 rtl/jtframe_pocket_dfifo.sv | 49 ++++
 rtl/jtframe_pocket_dwnld.sv | 174 +++++++++++++++++
 tb/tb_jtframe_pocket_dwnld.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_pocket_pkg.sv
// jtframe_pocket_pkg: shared constants, FSM states and parameter
// legality helpers for the Pocket download serialiser.
package jtframe_pocket_pkg;

  localparam logic [7:0] BRIDGE_PAGE = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_WAIT
  } dwnld_state_e;

  function automatic bit dw_legal(int dw);
    return (dw == 8) || (dw == 16);
  endfunction

  function automatic bit fifo_aw_legal(int aw);
    return (aw >= 1) && (aw <= 16);
  endfunction

endpackage

// File: rtl/jtframe_pocket_dwnld_if.sv
// jtframe_pocket_dwnld_if: ioctl/prog chunk bus between the
// download serialiser (master) and the ROM loader (slave).
interface jtframe_pocket_dwnld_if #(
  parameter int DW = 8,
  parameter int AW = 25
);
  logic [AW-1:0] ioctl_addr;
  logic [DW-1:0] ioctl_dout;
  logic          ioctl_wr;
  logic [7:0]    ioctl_index;
  logic          prog_rdy;

  modport master (
    output ioctl_addr,
    output ioctl_dout,
    output ioctl_wr,
    output ioctl_index,
    input  prog_rdy
  );

  modport slave (
    input  ioctl_addr,
    input  ioctl_dout,
    input  ioctl_wr,
    input  ioctl_index,
    output prog_rdy
  );
endinterface

// File: rtl/jtframe_pocket_dfifo.sv
// jtframe_pocket_dfifo: single-clock first-word-fall-through FIFO;
// a push into a full FIFO is kept when a pop happens that same cycle.
module jtframe_pocket_dfifo #(
  parameter int W  = 65,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp_q, wp_d;
  logic [AW:0]  rp_q, rp_d;
  logic         wr_en, rd_en;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rp_q[AW-1:0]];

  always_comb begin
    wp_d = wp_q + (AW+1)'(wr_en);
    rp_d = rp_q + (AW+1)'(rd_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jtframe_pocket_dwnld.sv
// jtframe_pocket_dwnld: queues bridge words and replays them as
// DW-bit ioctl chunks paced by prog_rdy; decodes the core-mode slot.
module jtframe_pocket_dwnld
  import jtframe_pocket_pkg::*;
#(
  parameter int         DW        = 8,
  parameter int         FIFO_AW   = 3,
  parameter int         MSB_FIRST = 0,
  parameter int         AW        = 25,
  parameter logic [7:0] MOD_SLOT  = 8'd1
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        bus_wr,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_data,
  input  logic [7:0]  slot_id,
  input  logic        slot_done,
  jtframe_pocket_dwnld_if.master io,
  output logic        downloading,
  output logic [6:0]  core_mod,
  output logic        ovf,
  output logic        busy
);
  localparam int NK   = 32 / DW;
  localparam int STEP = DW / 8;
  localparam int FW   = 8 + AW + 32;

  if (!dw_legal(DW)) begin : g_bad_dw
    $error("jtframe_pocket_dwnld: DW must be 8 or 16");
  end
  if (!fifo_aw_legal(FIFO_AW)) begin : g_bad_faw
    $error("jtframe_pocket_dwnld: FIFO_AW out of range");
  end

  function automatic logic [DW-1:0] chunk(
    input logic [31:0] w,
    input logic [1:0]  k
  );
    int sh;
    sh = (MSB_FIRST != 0) ? 32 - DW * (int'(k) + 1)
                          : DW * int'(k);
    return DW'(w >> sh);
  endfunction

  logic          acc, pop, full, empty;
  logic [FW-1:0] fifo_din, fifo_dout;
  logic [7:0]    f_slot;
  logic [AW-1:0] f_addr;
  logic [31:0]   f_data;

  dwnld_state_e  st_q, st_d;
  logic [1:0]    k_q, k_d;
  logic [31:0]   data_q, data_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [7:0]    idx_q, idx_d;
  logic          wr_q, wr_d;
  logic [6:0]    mod_q, mod_d;
  logic          ovf_q, ovf_d;
  logic          dl_q, dl_d;

  assign acc      = bus_wr && (bus_addr[31:24] != BRIDGE_PAGE);
  assign fifo_din = {slot_id, bus_addr[AW-1:0], bus_data};
  assign f_slot   = fifo_dout[FW-1 -: 8];
  assign f_addr   = fifo_dout[32 +: AW];
  assign f_data   = fifo_dout[31:0];
  assign pop      = (st_q == ST_IDLE) && !empty;
  assign busy     = !empty || (st_q != ST_IDLE);

  jtframe_pocket_dfifo #(
    .W  (FW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk_rom),
    .rst   (rst),
    .push  (acc),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    st_d   = st_q;
    k_d    = k_q;
    data_d = data_q;
    base_d = base_q;
    addr_d = addr_q;
    dout_d = dout_q;
    idx_d  = idx_q;
    wr_d   = 1'b0;
    mod_d  = mod_q;
    ovf_d  = ovf_q | (acc & full & ~pop);
    dl_d   = dl_q;
    if (slot_done && !busy) dl_d = 1'b0;
    if (acc && slot_id != MOD_SLOT) dl_d = 1'b1;
    unique case (st_q)
      ST_IDLE: begin
        if (!empty) begin
          st_d   = ST_EMIT;
          k_d    = 2'd0;
          data_d = f_data;
          base_d = f_addr;
          idx_d  = f_slot;
          addr_d = f_addr;
          dout_d = chunk(f_data, 2'd0);
          wr_d   = (f_slot != MOD_SLOT);
        end
      end
      ST_EMIT: begin
        st_d = ST_WAIT;
        // mode words bypass the loader entirely
        if (idx_q == MOD_SLOT) begin
          st_d = ST_IDLE;
          if (k_q == 2'd0 && base_q == '0) mod_d = dout_q[6:0];
        end
      end
      ST_WAIT: begin
        if (io.prog_rdy) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'(NK - 1)) begin
            st_d = ST_IDLE;
          end else begin
            st_d   = ST_EMIT;
            addr_d = base_q + AW'((int'(k_q) + 1) * STEP);
            dout_d = chunk(data_q, k_q + 2'd1);
            wr_d   = 1'b1;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      k_q    <= '0;
      data_q <= '0;
      base_q <= '0;
      addr_q <= '0;
      dout_q <= '0;
      idx_q  <= '0;
      wr_q   <= 1'b0;
      mod_q  <= '0;
      ovf_q  <= 1'b0;
      dl_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      k_q    <= k_d;
      data_q <= data_d;
      base_q <= base_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      idx_q  <= idx_d;
      wr_q   <= wr_d;
      mod_q  <= mod_d;
      ovf_q  <= ovf_d;
      dl_q   <= dl_d;
    end
  end

  assign io.ioctl_addr  = addr_q;
  assign io.ioctl_dout  = dout_q;
  assign io.ioctl_wr    = wr_q;
  assign io.ioctl_index = idx_q;
  assign downloading    = dl_q;
  assign core_mod       = mod_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// tb_jtframe_pocket_dwnld: directed checks of two serialiser
// builds (DW=8 LSB-first shallow FIFO, DW=16 MSB-first).
module tb_jtframe_pocket_dwnld;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        bus_wr, slot_done;
  logic [31:0] bus_addr, bus_data;
  logic [7:0]  slot_id;
  logic        downloading, ovf, busy;
  logic [6:0]  core_mod;

  logic        b_wr, b_done;
  logic [31:0] b_addr, b_data;
  logic [7:0]  b_slot;
  logic        b_dl, b_ovf, b_busy;
  logic [6:0]  b_mod;

  jtframe_pocket_dwnld_if #(.DW(8), .AW(25)) ifa ();
  jtframe_pocket_dwnld_if #(.DW(16), .AW(25)) ifb ();

  jtframe_pocket_dwnld #(
    .DW(8), .FIFO_AW(2), .MSB_FIRST(0), .AW(25), .MOD_SLOT(8'd1)
  ) u_a (
    .clk_rom     (clk),
    .rst         (rst),
    .bus_wr      (bus_wr),
    .bus_addr    (bus_addr),
    .bus_data    (bus_data),
    .slot_id     (slot_id),
    .slot_done   (slot_done),
    .io          (ifa),
    .downloading (downloading),
    .core_mod    (core_mod),
    .ovf         (ovf),
    .busy        (busy)
  );

  jtframe_pocket_dwnld #(
    .DW(16), .FIFO_AW(3), .MSB_FIRST(1), .AW(25), .MOD_SLOT(8'd1)
  ) u_b (
    .clk_rom     (clk),
    .rst         (rst),
    .bus_wr      (b_wr),
    .bus_addr    (b_addr),
    .bus_data    (b_data),
    .slot_id     (b_slot),
    .slot_done   (b_done),
    .io          (ifb),
    .downloading (b_dl),
    .core_mod    (b_mod),
    .ovf         (b_ovf),
    .busy        (b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst_a();
    chk("rst_addr", 64'(ifa.ioctl_addr), 0);
    chk("rst_dout", 64'(ifa.ioctl_dout), 0);
    chk("rst_wr", 64'(ifa.ioctl_wr), 0);
    chk("rst_index", 64'(ifa.ioctl_index), 0);
    chk("rst_dl", 64'(downloading), 0);
    chk("rst_mod", 64'(core_mod), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_busy", 64'(busy), 0);
  endtask

  task automatic wr_a(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [7:0]  s);
    bus_wr   = 1'b1;
    bus_addr = a;
    bus_data = d;
    slot_id  = s;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic cnt_wr_a(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ifa.ioctl_wr) c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [7:0] exp1 [4];
  int p, c;
  bit found;

  initial begin
    exp1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1;
    bus_wr = 0; bus_addr = 0; bus_data = 0; slot_id = 0;
    slot_done = 0; ifa.prog_rdy = 0;
    b_wr = 0; b_addr = 0; b_data = 0; b_slot = 0;
    b_done = 0; ifb.prog_rdy = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_rst_a();
    chk("b_rst_busy", 64'(b_busy), 0);
    chk("b_rst_wr", 64'(ifb.ioctl_wr), 0);

    // DW=8 LSB-first, prog_rdy held high
    ifa.prog_rdy = 1'b1;
    wr_a(32'h100, 32'h44332211, 8'd0);
    chk("t1_busy", 64'(busy), 1);
    chk("t1_wr_early", 64'(ifa.ioctl_wr), 0);
    chk("t1_dl", 64'(downloading), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_wr", 64'(ifa.ioctl_wr), 1);
      chk("t1_addr", 64'(ifa.ioctl_addr), 64'(32'h100 + k));
      chk("t1_dout", 64'(ifa.ioctl_dout), 64'(exp1[k]));
      chk("t1_index", 64'(ifa.ioctl_index), 0);
      @(negedge clk);
      chk("t1_wr_gap", 64'(ifa.ioctl_wr), 0);
    end
    @(negedge clk);
    chk("t1_idle", 64'(busy), 0);

    // DW=16 MSB-first
    ifb.prog_rdy = 1'b1;
    b_wr = 1'b1; b_addr = 32'h20; b_data = 32'hAABBCCDD; b_slot = 0;
    @(negedge clk);
    b_wr = 1'b0;
    @(negedge clk);
    chk("t2_wr0", 64'(ifb.ioctl_wr), 1);
    chk("t2_addr0", 64'(ifb.ioctl_addr), 64'h20);
    chk("t2_dout0", 64'(ifb.ioctl_dout), 64'hAABB);
    @(negedge clk);
    chk("t2_gap", 64'(ifb.ioctl_wr), 0);
    @(negedge clk);
    chk("t2_wr1", 64'(ifb.ioctl_wr), 1);
    chk("t2_addr1", 64'(ifb.ioctl_addr), 64'h22);
    chk("t2_dout1", 64'(ifb.ioctl_dout), 64'hCCDD);
    repeat (2) @(negedge clk);
    chk("t2_idle", 64'(b_busy), 0);

    // overflow: 6 writes into 1 FSM slot + 4 FIFO entries
    ifa.prog_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_wr   = 1'b1;
      bus_addr = 32'h200 + 32'(4 * i);
      bus_data = {4'(i), 4'h3, 4'(i), 4'h2, 4'(i), 4'h1, 4'(i), 4'h0};
      slot_id  = 8'd0;
      if (i == 5) chk("t3_ovf_pre", 64'(ovf), 0);
      @(negedge clk);
    end
    bus_wr = 1'b0;
    chk("t3_ovf", 64'(ovf), 1);
    chk("t3_hold_addr", 64'(ifa.ioctl_addr), 64'h200);
    ifa.prog_rdy = 1'b1;
    p = 1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (ifa.ioctl_wr) begin
        if (p < 20) begin
          chk("t3_addr", 64'(ifa.ioctl_addr), 64'(32'h200 + p));
          chk("t3_dout", 64'(ifa.ioctl_dout), 64'({4'(p / 4), 4'(p % 4)}));
        end
        p++;
      end
    end
    chk("t3_count", 64'(p), 20);
    chk("t3_idle", 64'(busy), 0);
    chk("t3_ovf_sticky", 64'(ovf), 1);

    // bridge page and mode slot
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_ovf_clr", 64'(ovf), 0);
    chk("t4_dl_clr", 64'(downloading), 0);
    wr_a(32'hF8000000, 32'h12345678, 8'd0);
    cnt_wr_a(5, c);
    chk("t4_bridge_wr", 64'(c), 0);
    chk("t4_bridge_dl", 64'(downloading), 0);
    chk("t4_bridge_busy", 64'(busy), 0);
    wr_a(32'h0, 32'h0000002A, 8'd1);
    cnt_wr_a(5, c);
    chk("t4_mod_wr", 64'(c), 0);
    chk("t4_mod", 64'(core_mod), 64'h2A);
    chk("t4_mod_dl", 64'(downloading), 0);

    // slot_done while two words are pending
    ifa.prog_rdy = 1'b0;
    wr_a(32'h500, 32'h01020304, 8'd0);
    wr_a(32'h504, 32'h05060708, 8'd0);
    slot_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_dl_hold", 64'(downloading), 1);
    chk("t5_busy", 64'(busy), 1);
    ifa.prog_rdy = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    chk("t5_drain", 64'(found), 1);
    chk("t5_dl_last", 64'(downloading), 1);
    @(negedge clk);
    chk("t5_dl_fall", 64'(downloading), 0);
    slot_done = 1'b0;

    // reset mid-word, then a fresh word
    wr_a(32'h300, 32'h88776655, 8'd0);
    repeat (3) @(negedge clk);
    chk("t6_k1_wr", 64'(ifa.ioctl_wr), 1);
    chk("t6_k1_addr", 64'(ifa.ioctl_addr), 64'h301);
    chk("t6_k1_dout", 64'(ifa.ioctl_dout), 64'h66);
    rst = 1'b1;
    #1;
    chk_rst_a();
    @(negedge clk);
    rst = 1'b0;
    wr_a(32'h400, 32'h11223344, 8'd0);
    @(negedge clk);
    chk("t6_new_wr", 64'(ifa.ioctl_wr), 1);
    chk("t6_new_addr", 64'(ifa.ioctl_addr), 64'h400);
    chk("t6_new_dout", 64'(ifa.ioctl_dout), 64'h44);
    repeat (2) @(negedge clk);
    chk("t6_new_addr1", 64'(ifa.ioctl_addr), 64'h401);
    chk("t6_new_dout1", 64'(ifa.ioctl_dout), 64'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
